piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 117 +++++++++++
 tb/tb_piso_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word with a valid/ready
// handshake and emits it one bit per cycle, MSB or LSB first, with zero-bubble
// back-to-back reload on the last bit of a word.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic last_c;
    logic ready_c;
    logic accept_c;
    logic head_c;

    // Handshake decode from registered state only
    always_comb begin
        last_c   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        ready_c  = (state_q == IDLE) || last_c;
        accept_c = load_valid && ready_c;
        head_c   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end

    // State, counter and shift register flops with async active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: enter or stay in SHIFT on accept, leave after the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_c && !accept_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, otherwise shift and count while in SHIFT
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (accept_c) begin
            cnt_d   = '0;
            shreg_d = load_data;
        end else if (state_q == SHIFT) begin
            // Leaving SHIFT clears the count so non-power-of-two widths restart at 0
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    // Outputs decoded from state; idle line is forced to zero
    always_comb begin
        load_ready = 1'b1;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        word_done  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                load_ready = last_c;
                ser_out    = head_c;
                ser_valid  = 1'b1;
                word_done  = last_c;
                busy       = 1'b1;
            end
            default: begin
                load_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first instance.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_data = '0;
    logic [7:0] b_data = '0;
    logic       a_valid = 1'b0;
    logic       b_valid = 1'b0;
    logic       a_ready, a_ser, a_sv, a_done, a_busy;
    logic       b_ready, b_ser, b_sv, b_done, b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int det_cnt  = 0;
    int det_base = 0;
    int n_a_bits = 0;
    logic [3:0] hist = '0;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (a_data),
        .load_valid (a_valid),
        .load_ready (a_ready),
        .ser_out    (a_ser),
        .ser_valid  (a_sv),
        .word_done  (a_done),
        .busy       (a_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_data  (b_data),
        .load_valid (b_valid),
        .load_ready (b_ready),
        .ser_out    (b_ser),
        .ser_valid  (b_sv),
        .word_done  (b_done),
        .busy       (b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push hand-computed emission order (leftmost bit first) into a scoreboard
    task automatic push_seq(input bit to_b, input logic [15:0] seq, input logic [15:0] done_mask,
                            input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b = seq[n-1-i];
            e.d = done_mask[n-1-i];
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a DUT presents a valid bit
    always @(negedge clk) begin
        exp_t e;
        check("a_busy_vs_valid", 32'(a_busy), 32'(a_sv));
        if (a_sv) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_bit: got ser_out=%0b with empty scoreboard at %0t", a_ser, $time);
            end else begin
                e = qa.pop_front();
                check("a_ser_out", 32'(a_ser), 32'(e.b));
                check("a_word_done", 32'(a_done), 32'(e.d));
            end
            hist = {hist[2:0], a_ser};
            n_a_bits++;
            if (n_a_bits >= 4 && hist == 4'b1010) det_cnt++;
        end else begin
            check("a_idle_ser_out", 32'(a_ser), 32'd0);
            check("a_idle_word_done", 32'(a_done), 32'd0);
        end

        check("b_busy_vs_valid", 32'(b_busy), 32'(b_sv));
        if (b_sv) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_bit: got ser_out=%0b with empty scoreboard at %0t", b_ser, $time);
            end else begin
                e = qb.pop_front();
                check("b_ser_out", 32'(b_ser), 32'(e.b));
                check("b_word_done", 32'(b_done), 32'(e.d));
            end
        end else begin
            check("b_idle_ser_out", 32'(b_ser), 32'd0);
            check("b_idle_word_done", 32'(b_done), 32'd0);
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_ready", 32'(a_ready), 32'd1);
        check("rst_ser_out", 32'(a_ser), 32'd0);
        check("rst_ser_valid", 32'(a_sv), 32'd0);
        check("rst_word_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        reset = 1'b0;

        // Single word A5 MSB-first, 05 LSB-first, accepted at first edge after reset
        push_seq(1'b0, 16'b10100101, 16'b00000001, 8);
        push_seq(1'b1, 16'b10100000, 16'b00000001, 8);
        a_valid = 1'b1; a_data = 8'hA5;
        b_valid = 1'b1; b_data = 8'h05;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check("w1_load_ready", 32'(a_ready), (k == 8) ? 32'd1 : 32'd0);
            check("w1_busy", 32'(a_busy), 32'd1);
            step();
        end
        check("w1_end_busy", 32'(a_busy), 32'd0);
        check("w1_end_ser_out", 32'(a_ser), 32'd0);
        check("w1_end_load_ready", 32'(a_ready), 32'd1);
        check("w1_end_b_busy", 32'(b_busy), 32'd0);

        // Busy-ignore on 3C with FF offered during cycles 1..7; LSB-first C1
        push_seq(1'b0, 16'b00111100, 16'b00000001, 8);
        push_seq(1'b1, 16'b10000011, 16'b00000001, 8);
        a_valid = 1'b1; a_data = 8'h3C;
        b_valid = 1'b1; b_data = 8'hC1;
        step();
        a_data  = 8'hFF;
        b_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check("ign_load_ready", 32'(a_ready), 32'd0);
            step();
        end
        a_valid = 1'b0;
        check("ign_last_load_ready", 32'(a_ready), 32'd1);
        step();
        check("ign_end_busy", 32'(a_busy), 32'd0);
        step();

        // Back-to-back A0 then 0A, no bubble
        push_seq(1'b0, 16'b1010000000001010, 16'b0000000100000001, 16);
        det_base = det_cnt;
        a_valid = 1'b1; a_data = 8'hA0;
        step();
        a_data = 8'h0A;
        for (int k = 1; k <= 8; k++) begin
            check("b2b_load_ready", 32'(a_ready), (k == 8) ? 32'd1 : 32'd0);
            step();
        end
        a_valid = 1'b0;
        for (int k = 9; k <= 16; k++) begin
            check("b2b_busy", 32'(a_busy), 32'd1);
            check("b2b_load_ready2", 32'(a_ready), (k == 16) ? 32'd1 : 32'd0);
            step();
        end
        check("b2b_end_busy", 32'(a_busy), 32'd0);
        check("b2b_detector_hits", 32'(det_cnt - det_base), 32'd2);
        step();

        // Reset mid-word: FF accepted, reset asserted cycle 3, released cycle 5
        push_seq(1'b0, 16'b11, 16'b00, 2);
        a_valid = 1'b1; a_data = 8'hFF;
        step();
        a_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_load_ready", 32'(a_ready), 32'd1);
        check("mid_rst_ser_out", 32'(a_ser), 32'd0);
        check("mid_rst_ser_valid", 32'(a_sv), 32'd0);
        check("mid_rst_word_done", 32'(a_done), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        step();
        step();
        reset = 1'b0;
        check("post_rst_load_ready", 32'(a_ready), 32'd1);
        push_seq(1'b0, 16'b10000001, 16'b00000001, 8);
        a_valid = 1'b1; a_data = 8'h81;
        step();
        a_valid = 1'b0;
        check("post_rst_busy", 32'(a_busy), 32'd1);
        repeat (8) step();
        check("post_rst_end_busy", 32'(a_busy), 32'd0);
        step();

        check("a_scoreboard_empty", 32'(qa.size()), 32'd0);
        check("b_scoreboard_empty", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
